// File: rtl/mem_wb_multi_if.sv
// One pipeline-stage bundle of write-back channels plus the HI/LO write.
// Used twice per register: MEM-side inputs (slave) and WB-side outputs (master).
interface mem_wb_multi_if #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();
  logic [NCH-1:0]        valid;
  logic [NCH*ADDR_W-1:0] wd;
  logic [NCH-1:0]        wreg;
  logic [NCH*DATA_W-1:0] wdata;
  logic                  whilo;
  logic [DATA_W-1:0]     hi;
  logic [DATA_W-1:0]     lo;

  modport master (output valid, wd, wreg, wdata, whilo, hi, lo);
  modport slave  (input  valid, wd, wreg, wdata, whilo, hi, lo);
endinterface

// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register: bubble/hold stall semantics, younger-wins destination
// collision resolution and a retired-instruction counter.
module mem_wb_multi #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall_mem,
  input  logic               stall_wb,
  mem_wb_multi_if.slave      mem,
  mem_wb_multi_if.master     wb,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef enum logic [1:0] {ActCapture, ActBubble, ActHold} act_e;

  act_e                  act;
  logic [NCH-1:0]        wreg_raw;
  logic [NCH-1:0]        wreg_res;
  logic [CNT_W-1:0]      pop;

  logic [NCH-1:0]        valid_q;
  logic [NCH*ADDR_W-1:0] wd_q;
  logic [NCH-1:0]        wreg_q;
  logic [NCH*DATA_W-1:0] wdata_q;
  logic                  whilo_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;
  logic [CNT_W-1:0]      cnt_q;

  // Flush beats everything; stall_mem without stall_wb drains a bubble into WB.
  always_comb begin
    act = ActCapture;
    if (flush) begin
      act = ActBubble;
    end else if (stall_mem && !stall_wb) begin
      act = ActBubble;
    end else if (!stall_mem) begin
      act = ActCapture;
    end else begin
      act = ActHold;
    end
  end

  always_comb begin
    wreg_raw = '0;
    wreg_res = '0;
    pop      = '0;
    for (int i = 0; i < NCH; i++) begin
      wreg_raw[i] = mem.wreg[i] & mem.valid[i] & (mem.wd[i*ADDR_W +: ADDR_W] != '0);
      pop         = pop + CNT_W'(mem.valid[i]);
    end
    // A younger slot writing the same register supersedes the older one.
    for (int i = 0; i < NCH; i++) begin
      wreg_res[i] = wreg_raw[i];
      for (int j = i + 1; j < NCH; j++) begin
        if (wreg_raw[j] && (mem.wd[j*ADDR_W +: ADDR_W] == mem.wd[i*ADDR_W +: ADDR_W])) begin
          wreg_res[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      wd_q    <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (act)
        ActBubble: begin
          valid_q <= '0;
          wd_q    <= '0;
          wreg_q  <= '0;
          wdata_q <= '0;
          whilo_q <= 1'b0;
          hi_q    <= '0;
          lo_q    <= '0;
        end
        ActCapture: begin
          valid_q <= mem.valid;
          wd_q    <= mem.wd;
          wreg_q  <= wreg_res;
          wdata_q <= mem.wdata;
          whilo_q <= mem.whilo & (|mem.valid);
          hi_q    <= mem.hi;
          lo_q    <= mem.lo;
          cnt_q   <= cnt_q + pop;
        end
        default: ;
      endcase
    end
  end

  assign wb.valid   = valid_q;
  assign wb.wd      = wd_q;
  assign wb.wreg    = wreg_q;
  assign wb.wdata   = wdata_q;
  assign wb.whilo   = whilo_q;
  assign wb.hi      = hi_q;
  assign wb.lo      = lo_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_multi.sv
// Bench for mem_wb_multi: vector table plus a 4-bit-counter instance for wrap.
module tb_mem_wb_multi;

  logic clk = 1'b0;
  logic rst, flush, stall_mem, stall_wb;
  logic [31:0] cnt32;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  mem_wb_multi_if #(.NCH(2), .DATA_W(32), .ADDR_W(5)) mem_if ();
  mem_wb_multi_if #(.NCH(2), .DATA_W(32), .ADDR_W(5)) wb_if ();
  mem_wb_multi_if #(.NCH(2), .DATA_W(32), .ADDR_W(5)) wb4_if ();

  mem_wb_multi #(.NCH(2), .DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem(mem_if), .wb(wb_if), .retire_cnt(cnt32)
  );

  mem_wb_multi #(.NCH(2), .DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem(mem_if), .wb(wb4_if), .retire_cnt(cnt4)
  );

  typedef struct {
    logic rst, flush, sm, sw;
    logic [1:0] valid;
    logic [4:0] wd1, wd0;
    logic [1:0] wreg;
    logic [31:0] d1, d0;
    logic whilo;
    logic [31:0] hi, lo;
    logic [1:0] exp_wreg;
    logic exp_whilo;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [1:0]  valid;
    logic [9:0]  wd;
    logic [1:0]  wreg;
    logic [63:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo, cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  vec_t tbl[22];
  int n_checks = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic r, input logic f, input logic sm, input logic sw,
                              input logic [1:0] va, input logic [4:0] w1, input logic [4:0] w0,
                              input logic [1:0] we, input logic [31:0] d1, input logic [31:0] d0,
                              input logic hl, input logic [31:0] hi, input logic [31:0] lo,
                              input logic [1:0] ew, input logic eh, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.flush = f; v.sm = sm; v.sw = sw; v.valid = va; v.wd1 = w1; v.wd0 = w0;
    v.wreg = we; v.d1 = d1; v.d0 = d0; v.whilo = hl; v.hi = hi; v.lo = lo;
    v.exp_wreg = ew; v.exp_whilo = eh; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    rst = v.rst; flush = v.flush; stall_mem = v.sm; stall_wb = v.sw;
    mem_if.valid = v.valid; mem_if.wd = {v.wd1, v.wd0}; mem_if.wreg = v.wreg;
    mem_if.wdata = {v.d1, v.d0}; mem_if.whilo = v.whilo; mem_if.hi = v.hi; mem_if.lo = v.lo;
    if (!v.rst || v.flush || (v.sm && !v.sw)) begin
      e = '{valid: '0, wd: '0, wreg: '0, wdata: '0, whilo: 1'b0, hi: '0, lo: '0, cnt: '0};
    end else if (!v.sm) begin
      e.valid = v.valid; e.wd = {v.wd1, v.wd0}; e.wdata = {v.d1, v.d0};
      e.hi = v.hi; e.lo = v.lo;
    end else begin
      e = cur;
    end
    e.wreg = v.exp_wreg; e.whilo = v.exp_whilo; e.cnt = v.exp_cnt;
    cur = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", idx, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk("wb_valid", idx, 64'(wb_if.valid), 64'(e.valid));
      chk("wb_wd", idx, 64'(wb_if.wd), 64'(e.wd));
      chk("wb_wreg", idx, 64'(wb_if.wreg), 64'(e.wreg));
      chk("wb_wdata", idx, wb_if.wdata, e.wdata);
      chk("wb_whilo", idx, 64'(wb_if.whilo), 64'(e.whilo));
      chk("wb_hi", idx, 64'(wb_if.hi), 64'(e.hi));
      chk("wb_lo", idx, 64'(wb_if.lo), 64'(e.lo));
      chk("retire_cnt", idx, 64'(cnt32), 64'(e.cnt));
      chk("retire_cnt4", idx, 64'(cnt4), 64'(e.cnt[3:0]));
      chk("wb4_wreg", idx, 64'(wb4_if.wreg), 64'(e.wreg));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = '{valid: '0, wd: '0, wreg: '0, wdata: '0, whilo: 1'b0, hi: '0, lo: '0, cnt: '0};
    //            r f sm sw valid  wd1 wd0 wreg   d1        d0        hl hi        lo        ewreg  eh ecnt
    tbl[0]  = mk(0,0,0,0, 2'b11, 5, 3, 2'b11, 32'h11,   32'h22,   1, 32'h33,   32'h44,   2'b00, 0, 0);
    tbl[1]  = mk(0,0,0,0, 2'b11, 5, 3, 2'b11, 32'h11,   32'h22,   1, 32'h33,   32'h44,   2'b00, 0, 0);
    tbl[2]  = mk(1,0,0,0, 2'b11, 5, 3, 2'b11, 32'hB0B0, 32'hA0A0, 0, 0,        0,        2'b11, 0, 2);
    tbl[3]  = mk(1,0,0,0, 2'b11, 7, 7, 2'b11, 32'hBBBB, 32'hAAAA, 0, 0,        0,        2'b10, 0, 4);
    tbl[4]  = mk(1,0,0,0, 2'b01, 9, 0, 2'b11, 32'h99,   32'h88,   0, 0,        0,        2'b00, 0, 5);
    tbl[5]  = mk(1,0,0,0, 2'b11, 4, 2, 2'b11, 32'h44,   32'h22,   1, 32'h5,    32'h6,    2'b11, 1, 7);
    tbl[6]  = mk(1,0,1,0, 2'b11, 4, 2, 2'b11, 32'h1,    32'h2,    1, 32'h7,    32'h8,    2'b00, 0, 7);
    tbl[7]  = mk(1,0,0,0, 2'b11, 6, 1, 2'b01, 32'h66,   32'h11,   0, 32'h9,    32'hA,    2'b01, 0, 9);
    tbl[8]  = mk(1,0,1,1, 2'b11, 3, 3, 2'b11, 32'hF,    32'hF,    1, 32'hF,    32'hF,    2'b01, 0, 9);
    tbl[9]  = mk(1,0,1,1, 2'b11, 3, 3, 2'b11, 32'hF,    32'hF,    1, 32'hF,    32'hF,    2'b01, 0, 9);
    tbl[10] = mk(1,0,1,1, 2'b11, 3, 3, 2'b11, 32'hF,    32'hF,    1, 32'hF,    32'hF,    2'b01, 0, 9);
    tbl[11] = mk(1,1,1,1, 2'b11, 3, 3, 2'b11, 32'hF,    32'hF,    1, 32'hF,    32'hF,    2'b00, 0, 9);
    tbl[12] = mk(1,0,0,0, 2'b01, 0, 8, 2'b01, 32'h0,    32'h80,   1, 32'h1234, 32'h5678, 2'b01, 1, 10);
    tbl[13] = mk(1,0,0,0, 2'b00, 0, 8, 2'b01, 32'h0,    32'h80,   1, 32'h1234, 32'h5678, 2'b00, 0, 10);
    tbl[14] = mk(1,1,0,0, 2'b11, 2, 1, 2'b11, 32'h5,    32'h6,    1, 32'h1,    32'h1,    2'b00, 0, 10);
    tbl[15] = mk(1,0,0,1, 2'b10, 3, 0, 2'b10, 32'h33,   32'h0,    0, 0,        0,        2'b10, 0, 11);
    tbl[16] = mk(1,0,0,0, 2'b11, 7, 7, 2'b01, 32'h77,   32'h70,   0, 0,        0,        2'b01, 0, 13);
    tbl[17] = mk(1,0,0,0, 2'b01, 7, 7, 2'b11, 32'h77,   32'h70,   0, 0,        0,        2'b01, 0, 14);
    tbl[18] = mk(1,0,1,1, 2'b11, 1, 1, 2'b11, 32'h1,    32'h1,    1, 32'h1,    32'h1,    2'b01, 0, 14);
    tbl[19] = mk(0,0,1,1, 2'b11, 1, 1, 2'b11, 32'h1,    32'h1,    1, 32'h1,    32'h1,    2'b00, 0, 0);
    tbl[20] = mk(1,0,1,1, 2'b11, 1, 1, 2'b11, 32'h1,    32'h1,    1, 32'h1,    32'h1,    2'b00, 0, 0);
    tbl[21] = mk(1,0,0,0, 2'b11, 2, 1, 2'b11, 32'h21,   32'h12,   0, 0,        0,        2'b11, 0, 2);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i], i);
    end

    // Eight dual-slot captures take the 4-bit counter exactly once around.
    step(mk(0,0,0,0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0), 100);
    for (int k = 1; k <= 8; k++) begin
      step(mk(1,0,0,0, 2'b11, 2, 1, 2'b11, 32'(k), 32'(k + 16), 0, 0, 0, 2'b11, 0, 32'(2 * k)),
           100 + k);
    end
    chk("wrap_cnt4_zero", 200, 64'(cnt4), 64'd0);
    chk("wrap_cnt32_16", 200, 64'(cnt32), 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
